// File: rtl/arinc_word_assembler.sv
// arinc_word_assembler
// Packs four received bytes (LSB byte first) into one 32-bit ARINC429 word,
// flags odd-parity errors and label mismatches, and hands the word to the
// downstream buffer over a valid/ready handshake. A partial word that sits
// idle for TIMEOUT_CYCLES clocks is discarded.
//
// Optional feature macro: ARINC_LABEL_FILTER_EN
//   defined   : words whose label byte differs from label_cfg are discarded
//               silently; label_match then always reads 1.
//   undefined : every completed word is delivered; label_match carries the
//               label compare result.
//
// Assembly states
//   state | meaning
//   B0    | waiting for byte 0 (label), timeout counter held at 0
//   B1    | byte 0 stored, waiting for byte 1
//   B2    | bytes 0-1 stored, waiting for byte 2
//   B3    | bytes 0-2 stored, next byte completes the word

module arinc_word_assembler #(
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [7:0]  label_cfg,
    input  logic        out_ready,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic        parity_err,
    output logic        label_match,
    output logic        overrun,
    output logic        timeout_err
);

    typedef enum logic [1:0] {B0, B1, B2, B3} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [23:0]     r_shift;
    logic [TO_W-1:0] r_to_cnt;
    logic [31:0]     r_word_out;
    logic            r_word_valid;
    logic            r_parity_err;
    logic            r_label_match;
    logic            r_overrun;
    logic            r_timeout_err;

    logic            w_complete;
    logic            w_timeout;
    logic [31:0]     w_word;
    logic            w_label_ok;
    logic            w_deliver;
    logic            w_slot_free;
    logic            w_load;
    logic            w_drop;

    // Byte-count state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= B0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: advance on each byte; timeout resyncs to B0 unless a byte arrives
    always_comb begin
        w_state_nxt = r_state;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        if (rx_valid) begin
            case (r_state)
                B0: w_state_nxt = B1;
                B1: w_state_nxt = B2;
                B2: w_state_nxt = B3;
                B3: begin
                    w_state_nxt = B0;
                    w_complete  = 1'b1;
                end
                default: w_state_nxt = B0;
            endcase
        end else if ((r_state != B0) && (r_to_cnt == TO_LAST)) begin
            w_state_nxt = B0;
            w_timeout   = 1'b1;
        end
    end

    // The last byte is taken straight from rx_data so the word can load
    // on the same edge that samples it.
    assign w_word      = {rx_data, r_shift};
    assign w_label_ok  = (r_shift[7:0] == label_cfg);
    assign w_slot_free = ~r_word_valid | out_ready;

`ifdef ARINC_LABEL_FILTER_EN
    assign w_deliver = w_complete & w_label_ok;
`else
    assign w_deliver = w_complete;
`endif

    assign w_load = w_deliver & w_slot_free;
    assign w_drop = w_deliver & ~w_slot_free;

    // Place bytes 0..2 into their lanes; clear on completion or timeout
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_shift <= '0;
        end else if (w_timeout) begin
            r_shift <= '0;
        end else if (rx_valid) begin
            case (r_state)
                B0:      r_shift[7:0]   <= rx_data;
                B1:      r_shift[15:8]  <= rx_data;
                B2:      r_shift[23:16] <= rx_data;
                default: r_shift        <= '0;
            endcase
        end
    end

    // Inter-byte timer: runs only while a word is partially assembled
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_to_cnt <= '0;
        end else if (rx_valid || w_timeout || (r_state == B0)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Output slot: load when free, release on accept, pulse status flags
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_word_out    <= '0;
            r_word_valid  <= 1'b0;
            r_parity_err  <= 1'b0;
            r_label_match <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_overrun     <= w_drop;
            r_timeout_err <= w_timeout;
            if (w_load) begin
                r_word_out   <= w_word;
                r_word_valid <= 1'b1;
                r_parity_err <= ~^w_word;
`ifdef ARINC_LABEL_FILTER_EN
                r_label_match <= 1'b1;
`else
                r_label_match <= w_label_ok;
`endif
            end else if (r_word_valid && out_ready) begin
                r_word_valid <= 1'b0;
            end
        end
    end

    assign word_out    = r_word_out;
    assign word_valid  = r_word_valid;
    assign parity_err  = r_parity_err;
    assign label_match = r_label_match;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_arinc_word_assembler.sv
// Directed bench for arinc_word_assembler. Uses a short timeout so the
// timeout boundary can be exercised quickly.

module tb_arinc_word_assembler;

    localparam int TO_CYC = 64;

    logic        clk = 1'b0;
    logic        clr;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  label_cfg;
    logic        out_ready;
    logic [31:0] word_out;
    logic        word_valid;
    logic        parity_err;
    logic        label_match;
    logic        overrun;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    arinc_word_assembler #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(8)) dut (
        .clk         (clk),
        .clr         (clr),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .label_cfg   (label_cfg),
        .out_ready   (out_ready),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .parity_err  (parity_err),
        .label_match (label_match),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_word"},   word_out,    32'h0);
        chk({tag, "_valid"},  {31'b0, word_valid},  32'h0);
        chk({tag, "_par"},    {31'b0, parity_err},  32'h0);
        chk({tag, "_lbl"},    {31'b0, label_match}, 32'h0);
        chk({tag, "_ovr"},    {31'b0, overrun},     32'h0);
        chk({tag, "_to"},     {31'b0, timeout_err}, 32'h0);
    endtask

    initial begin
        clr       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        label_cfg = 8'h11;
        out_ready = 1'b1;
        tick();
        tick();
        chk_zero("reset");
        clr = 1'b0;
        tick();

        // T1: basic word, label match, good parity
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        chk("t1_no_early_valid", {31'b0, word_valid}, 32'h0);
        send_byte(8'h04);
        chk("t1_valid", {31'b0, word_valid}, 32'h1);
        chk("t1_word", word_out, 32'h04332211);
        chk("t1_par", {31'b0, parity_err}, 32'h0);
        chk("t1_lbl", {31'b0, label_match}, 32'h1);
        tick();
        chk("t1_valid_drop", {31'b0, word_valid}, 32'h0);

        // T2: even number of ones -> parity error
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h84);
        chk("t2_word", word_out, 32'h84332211);
        chk("t2_par", {31'b0, parity_err}, 32'h1);
        tick();

        // T3: partial word times out, next word clean
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (TO_CYC - 1) tick();
        chk("t3_to_not_yet", {31'b0, timeout_err}, 32'h0);
        tick();
        chk("t3_to_pulse", {31'b0, timeout_err}, 32'h1);
        tick();
        chk("t3_to_one_clk", {31'b0, timeout_err}, 32'h0);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h04);
        chk("t3_word", word_out, 32'h04332211);
        chk("t3_valid", {31'b0, word_valid}, 32'h1);
        tick();

        // T3b: byte arriving on the timeout cycle wins
        send_byte(8'h11);
        repeat (TO_CYC - 1) tick();
        send_byte(8'h22);
        chk("t3b_no_to", {31'b0, timeout_err}, 32'h0);
        send_byte(8'h33);
        send_byte(8'h04);
        chk("t3b_word", word_out, 32'h04332211);
        chk("t3b_valid", {31'b0, word_valid}, 32'h1);
        tick();

        // T4: slot held, second word overruns
        out_ready = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h04);
        chk("t4_valid", {31'b0, word_valid}, 32'h1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        chk("t4_no_ovr_yet", {31'b0, overrun}, 32'h0);
        send_byte(8'h05);
        chk("t4_ovr", {31'b0, overrun}, 32'h1);
        chk("t4_word_held", word_out, 32'h04332211);
        chk("t4_valid_held", {31'b0, word_valid}, 32'h1);
        tick();
        chk("t4_ovr_one_clk", {31'b0, overrun}, 32'h0);
        out_ready = 1'b1;
        tick();
        chk("t4_accept", {31'b0, word_valid}, 32'h0);

        // T4b: completion on the acceptance cycle loads the new word
        out_ready = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h04);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        out_ready = 1'b1;
        send_byte(8'h05);
        chk("t4b_word", word_out, 32'h05332211);
        chk("t4b_valid", {31'b0, word_valid}, 32'h1);
        chk("t4b_no_ovr", {31'b0, overrun}, 32'h0);
        tick();
        chk("t4b_accept", {31'b0, word_valid}, 32'h0);

        // T5: async clear mid-word discards everything
        out_ready = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h84);
        send_byte(8'h11);
        send_byte(8'h22);
        #2;
        clr = 1'b1;
        #1;
        chk_zero("t5_clr");
        tick();
        clr = 1'b0;
        out_ready = 1'b1;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h04);
        chk("t5_word", word_out, 32'h04332211);
        chk("t5_valid", {31'b0, word_valid}, 32'h1);
        tick();

        // T6: label mismatch
        send_byte(8'h55);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h04);
`ifdef ARINC_LABEL_FILTER_EN
        chk("t6_filtered", {31'b0, word_valid}, 32'h0);
        chk("t6_no_ovr", {31'b0, overrun}, 32'h0);
`else
        chk("t6_valid", {31'b0, word_valid}, 32'h1);
        chk("t6_lbl", {31'b0, label_match}, 32'h0);
        chk("t6_word", word_out, 32'h04332255);
        chk("t6_par", {31'b0, parity_err}, 32'h0);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
